core_run_sequencer: RTL
=======================

Name: core_run_sequencer

Overview:
- Top-level run controller for the 9-bit single-cycle core (PC, instruction memory, register file, ALU, data memory).
- Turns the external start/done handshake into core control signals:
  - a synchronous clear pulse for the PC and register file;
  - a per-cycle execute enable (core_en) gating PC advance and all register/memory writes.
- Detects program end: zero-instruction run, PC limit or watchdog timeout. Drains the last write, then raises done and reports the halt reason and the executed-cycle count.

Parameters:
PC_W, 8, program counter width
INSTR_W, 9, machine code width
CYC_W, 16, executed-cycle counter width
PC_LIMIT, 8'hFF, PC value that ends the program
ZERO_RUN, 1, consecutive all-zero instructions that end the program (1..15)
CLEAR_CYC, 2, cycles core_rst is held in CLEAR (1..15)
DRAIN_CYC, 1, cycles with core_en low between halt detect and done (1..15)
MAX_CYC, 65535, watchdog limit on executed cycles (<= 2^CYC_W-1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  run request, level; must return low before re-triggering
abort  in  1  force return to IDLE
pc  in  PC_W  current PC from program counter
instr  in  INSTR_W  current machine code from instruction memory
core_rst  out  1  synchronous clear to PC and register file
core_en  out  1  execute enable (PC advance, regfile/dmem write enables)
done  out  1  program finished, held until next run or abort
halt_reason  out  2  00 none, 01 zero-instr, 10 pc limit, 11 timeout
cycles  out  CYC_W  executed cycles (cycles with core_en=1), saturating

Behaviour:
- reset (async): state=IDLE, armed=1, done=0, core_en=0, core_rst=0, halt_reason=00, cycles=0, internal counters=0.
- States: IDLE, CLEAR, RUN, DRAIN, DONE. Registered, one transition per clock.
- armed: cleared when a run starts; set on any cycle start=0. A run starts only when start=1 && armed.
- IDLE: outputs low. start&&armed -> CLEAR.
- CLEAR:
  - core_rst=1, core_en=0.
  - On entry: cycles=0, halt_reason=00, zero counter=0.
  - After CLEAR_CYC cycles -> RUN.
- RUN:
  - core_en=1. Each clocked cycle in RUN: cycles+=1, saturating at all-ones.
  - Halt checks use pc/instr of the current cycle, in priority order:
    1. cycles+1 >= MAX_CYC -> reason 11.
    2. pc == PC_LIMIT -> reason 10.
    3. instr == 0 and zero counter+1 == ZERO_RUN -> reason 01.
  - Any instr != 0 resets the zero counter.
  - On halt: latch halt_reason, go to DRAIN. core_en drops the next cycle; the halting cycle's writes still commit.
- DRAIN: core_en=0, core_rst=0. After DRAIN_CYC cycles -> DONE.
- DONE:
  - done=1; cycles and halt_reason held.
  - start&&armed -> CLEAR; done falls on the same edge.
- abort=1 in any state: next state IDLE, done=0, core_en=0, core_rst=0; cycles and halt_reason held. abort has priority over every other transition.
- start held high through a whole run does not restart it after DONE; it must go low for at least one cycle first.
- reset mid-RUN: outputs go low immediately (async); the core is not cleared until the next CLEAR.

Optional Feature:
SEQ_SINGLE_STEP_EN
- Defined:
  - Adds inputs step_mode (1) and step (1).
  - In RUN with step_mode=1, core_en is high for exactly one cycle per rising edge of step (edge detected by a registered step).
  - cycles, the zero counter and the halt checks advance only on cycles with core_en=1.
  - step_mode=0 behaves as free-run.
- Undefined: ports absent; RUN asserts core_en every cycle.

Test Plan:
- Basic run: reset, start pulse.
  - core_rst high exactly 2 cycles, then core_en high.
  - instr=0 appears at the 10th RUN cycle -> halt_reason=01, cycles=10, core_en low 1 cycle, then done=1.
- PC limit: pc reaches 8'hFF on RUN cycle 5 while instr != 0 -> halt_reason=10, cycles=5, done after 1 drain cycle.
- Watchdog (MAX_CYC=20, no zero instr, pc never 8'hFF) -> halt_reason=11, cycles=20.
- Priority: pc==8'hFF and instr==0 in the same cycle -> halt_reason=10.
- Re-arm:
  - start held high through DONE -> stays in DONE, done=1.
  - Drop start 1 cycle, raise it -> done=0 on the same edge, new CLEAR, cycles reset to 0.
- Abort/reset: abort in RUN cycle 3 -> core_en=0 next cycle, done=0, cycles=3 held. Async reset mid-DRAIN -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/core_run_sequencer.sv
// core_run_sequencer
// Run controller for the 9-bit single-cycle core. Converts the external
// start/done handshake into a synchronous core clear (core_rst) and a
// per-cycle execute enable (core_en), detects program end (zero-instruction
// run, PC limit, watchdog), drains the last write and reports the result.
//
// Optional build macro: SEQ_SINGLE_STEP_EN adds step_mode/step inputs so RUN
// executes one cycle per rising edge of step while step_mode=1.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             run request (level, must drop before re-trigger)
//   abort             force return to IDLE
//   pc, instr         current PC and machine code from the core
//   core_rst          synchronous clear to PC and register file
//   core_en           execute enable for PC advance and all writes
//   done              program finished, held until next run or abort
//   halt_reason       00 none, 01 zero-instr, 10 pc limit, 11 timeout
//   cycles            executed cycles (core_en=1), saturating
//
// state | meaning
// IDLE  | waiting for an armed start
// CLEAR | core_rst held for CLEAR_CYC cycles
// RUN   | core executing, halt checks active
// DRAIN | core_en low for DRAIN_CYC cycles after halt
// DONE  | done high, result held
module core_run_sequencer #(
  parameter int              PC_W      = 8,
  parameter int              INSTR_W   = 9,
  parameter int              CYC_W     = 16,
  parameter logic [PC_W-1:0] PC_LIMIT  = {PC_W{1'b1}},
  parameter int              ZERO_RUN  = 1,
  parameter int              CLEAR_CYC = 2,
  parameter int              DRAIN_CYC = 1,
  parameter int              MAX_CYC   = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic               core_rst,
  output logic               core_en,
  output logic               done,
  output logic [1:0]         halt_reason,
  output logic [CYC_W-1:0]   cycles
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CYC_W:0] MAX_CYC_L   = (CYC_W+1)'(MAX_CYC);
  localparam logic [3:0]     ZERO_RUN_L  = 4'(ZERO_RUN);
  localparam logic [3:0]     CLEAR_LOAD  = 4'(CLEAR_CYC - 1);
  localparam logic [3:0]     DRAIN_LOAD  = 4'(DRAIN_CYC - 1);

  state_t           state_q, state_d;
  logic             armed_q;
  logic [3:0]       tmr_q;
  logic [3:0]       zc_q;
  logic [3:0]       zc_inc;
  logic [CYC_W:0]   cyc_inc;
  logic [1:0]       reason_d;
  logic             run_start;
  logic             run_en;
  logic             enter_clear;
  logic             enter_drain;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  // In step mode only a rising edge of step lets one cycle execute.
  assign run_en = ~step_mode | (step & ~step_q);
`else
  assign run_en = 1'b1;
`endif

  assign run_start = start & armed_q;
  assign cyc_inc   = {1'b0, cycles} + (CYC_W+1)'(1);
  assign zc_inc    = zc_q + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    core_rst = 1'b0;
    core_en  = 1'b0;
    done     = 1'b0;
    reason_d = 2'b00;
    case (state_q)
      IDLE: begin
        if (run_start) state_d = CLEAR;
      end
      CLEAR: begin
        core_rst = 1'b1;
        if (tmr_q == 4'd0) state_d = RUN;
      end
      RUN: begin
        core_en = run_en;
        if (run_en) begin
          if (cyc_inc >= MAX_CYC_L)                        reason_d = 2'b11;
          else if (pc == PC_LIMIT)                         reason_d = 2'b10;
          else if (instr == '0 && zc_inc == ZERO_RUN_L)    reason_d = 2'b01;
          if (reason_d != 2'b00) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tmr_q == 4'd0) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (run_start) state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Both flags already account for abort because state_d does.
  assign enter_clear = (state_d == CLEAR) && (state_q != CLEAR);
  assign enter_drain = (state_d == DRAIN) && (state_q == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q     <= 1'b1;
      tmr_q       <= 4'd0;
      zc_q        <= 4'd0;
      cycles      <= '0;
      halt_reason <= 2'b00;
    end else begin
      if (!start)           armed_q <= 1'b1;
      else if (enter_clear) armed_q <= 1'b0;

      if (enter_clear)        tmr_q <= CLEAR_LOAD;
      else if (enter_drain)   tmr_q <= DRAIN_LOAD;
      else if (tmr_q != 4'd0) tmr_q <= tmr_q - 4'd1;

      if (enter_clear) begin
        cycles      <= '0;
        halt_reason <= 2'b00;
        zc_q        <= 4'd0;
      end else begin
        // A cycle that executed still counts, even if abort arrives with it.
        if (core_en) begin
          if (cycles != '1) cycles <= cycles + 1'b1;
          zc_q <= (instr == '0) ? zc_inc : 4'd0;
        end
        if (enter_drain) halt_reason <= reason_d;
      end
    end
  end

endmodule
